fwd_hazard_ctrl: RTL and testbench

// - Control block on the select side of the EX-stage 3-input forwarding muxes (a=regfile, b=EX/MEM, c=MEM/WB) in the 5-stage MIPS pipeline.
// - Produces the registered 2-bit forwarding selects for the instruction entering EX.
// - Detects load-use hazards and stalls IF/ID. Sequences the multi-cycle mult/div unit and stalls HI/LO readers while it is busy.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 38 +++
 rtl/fwd_hazard_ctrl_if.sv | 45 ++++
 rtl/fwd_hazard_ctrl_md_busy_timer.sv | 65 ++++++
 rtl/fwd_hazard_ctrl.sv | 85 ++++++++
 tb/tb_fwd_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline-control constants: forwarding mux selects,
// mult/div FSM encoding and the $0 register index.
package cpu_ctrl_pkg;

  typedef logic [1:0] fwd_sel_t;
  typedef logic [4:0] reg_idx_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  localparam reg_idx_t REG_ZERO = 5'd0;

  // A load in EX has no result yet, so it never feeds EX/MEM.
  function automatic fwd_sel_t fwd_pick(
    input logic     ex_rw,
    input logic     ex_ld,
    input reg_idx_t ex_rd,
    input logic     mem_rw,
    input reg_idx_t mem_rd,
    input reg_idx_t rx
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ex_rw && !ex_ld && ex_rd != REG_ZERO &&
        ex_rd == rx)
      sel = FWD_EXMEM;
    else if (mem_rw && mem_rd != REG_ZERO &&
             mem_rd == rx)
      sel = FWD_MEMWB;
    return sel;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID/EX/MEM register info in, forwarding selects and
// stall/mult-div status out.
interface fwd_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import cpu_ctrl_pkg::*;

  reg_idx_t         id_rs;
  reg_idx_t         id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_md_start;
  logic             id_use_hilo;
  reg_idx_t         ex_rd;
  logic             ex_regwrite;
  logic             ex_memread;
  reg_idx_t         mem_rd;
  logic             mem_regwrite;
  fwd_sel_t         fwd_a_sel;
  fwd_sel_t         fwd_b_sel;
  logic             stall;
  logic             flush_idex;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output id_md_start, id_use_hilo,
    output ex_rd, ex_regwrite, ex_memread,
    output mem_rd, mem_regwrite,
    input  fwd_a_sel, fwd_b_sel, stall, flush_idex,
    input  md_busy, md_done, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  id_md_start, id_use_hilo,
    input  ex_rd, ex_regwrite, ex_memread,
    input  mem_rd, mem_regwrite,
    output fwd_a_sel, fwd_b_sel, stall, flush_idex,
    output md_busy, md_done, stall_cnt
  );

endinterface

// File: rtl/fwd_hazard_ctrl_md_busy_timer.sv
// Mult/div sequencer: busy for MD_LAT cycles after an
// accepted start, then a one-cycle done pulse.
module md_busy_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(MD_LAT);
  localparam logic [CW-1:0] LAST = CW'(MD_LAT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        MD_IDLE: begin
          if (start) begin
            state <= MD_BUSY;
            cnt   <= LAST;
            busy  <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt == '0) begin
            state <= MD_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MD_DONE: begin
          done <= 1'b0;
          // back-to-back op: skip idle, pulse already issued
          if (start) begin
            state <= MD_BUSY;
            cnt   <= LAST;
            busy  <= 1'b1;
          end else begin
            state <= MD_IDLE;
          end
        end
        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding selects, load-use and HI/LO stalls.
// Optional stall counter built when STALL_CNT_EN is defined.
module fwd_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  fwd_hazard_ctrl_if.slave hz
);

  logic     ld_haz;
  logic     md_haz;
  logic     stall_w;
  logic     md_busy;
  logic     md_done;
  fwd_sel_t a_nxt;
  fwd_sel_t b_nxt;

  always_comb begin
    ld_haz = hz.ex_memread &&
             hz.ex_rd != REG_ZERO &&
             ((hz.id_use_rs && hz.ex_rd == hz.id_rs) ||
              (hz.id_use_rt && hz.ex_rd == hz.id_rt));
    md_haz  = md_busy && hz.id_use_hilo;
    stall_w = ld_haz || md_haz;
  end

  always_comb begin
    a_nxt = FWD_RF;
    b_nxt = FWD_RF;
    // a stalled slot becomes a bubble with no operands
    if (!stall_w) begin
      a_nxt = fwd_pick(hz.ex_regwrite, hz.ex_memread,
                       hz.ex_rd, hz.mem_regwrite,
                       hz.mem_rd, hz.id_rs);
      b_nxt = fwd_pick(hz.ex_regwrite, hz.ex_memread,
                       hz.ex_rd, hz.mem_regwrite,
                       hz.mem_rd, hz.id_rt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz.fwd_a_sel <= FWD_RF;
      hz.fwd_b_sel <= FWD_RF;
    end else begin
      hz.fwd_a_sel <= a_nxt;
      hz.fwd_b_sel <= b_nxt;
    end
  end

  md_busy_timer #(
    .MD_LAT (MD_LAT)
  ) u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .start (hz.id_md_start && !stall_w),
    .busy  (md_busy),
    .done  (md_done)
  );

  assign hz.stall      = stall_w;
  assign hz.flush_idex = stall_w;
  assign hz.md_busy    = md_busy;
  assign hz.md_done    = md_done;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (stall_w)
      cnt_q <= cnt_q + 1'b1;
  end

  assign hz.stall_cnt = cnt_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with a cycle-level
// reference model and per-cycle output comparison.
module tb_fwd_hazard_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int LAT = 4;
`ifdef STALL_CNT_EN
  localparam logic [31:0] CNT3 = 32'd3;
`else
  localparam logic [31:0] CNT3 = 32'd0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  fwd_hazard_ctrl_if hz ();

  fwd_hazard_ctrl #(
    .MD_LAT (LAT),
    .CNT_W  (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc  = 0;
  int          st_e = -1000;
  logic [1:0]  ea   = 2'b00;
  logic [1:0]  eb   = 2'b00;
  logic [31:0] ecnt = 32'd0;
  logic        e_busy;
  logic        e_done;
  logic        e_stall;

  function automatic logic [1:0] src_of(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (hz.ex_regwrite && !hz.ex_memread && hz.ex_rd == r)
      return 2'b01;
    if (hz.mem_regwrite && hz.mem_rd == r)
      return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    e_busy  = (cyc - st_e) >= 0 && (cyc - st_e) < LAT;
    e_done  = (cyc - st_e) == LAT;
    e_stall = (e_busy && hz.id_use_hilo) ||
              (hz.ex_memread && hz.ex_rd != 5'd0 &&
               ((hz.id_use_rs && hz.id_rs == hz.ex_rd) ||
                (hz.id_use_rt && hz.id_rt == hz.ex_rd)));
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc  <= 0;
      st_e <= -1000;
      ea   <= 2'b00;
      eb   <= 2'b00;
      ecnt <= 32'd0;
    end else begin
      cyc <= cyc + 1;
      if (hz.id_md_start && !e_stall && !e_busy)
        st_e <= cyc + 1;
      ea <= e_stall ? 2'b00 : src_of(hz.id_rs);
      eb <= e_stall ? 2'b00 : src_of(hz.id_rt);
`ifdef STALL_CNT_EN
      if (e_stall) ecnt <= ecnt + 32'd1;
`endif
    end
  end

  always @(negedge clk) begin
    chk("m_stall", 32'(hz.stall), 32'(e_stall));
    chk("m_flush", 32'(hz.flush_idex), 32'(e_stall));
    chk("m_fwd_a", 32'(hz.fwd_a_sel), 32'(ea));
    chk("m_fwd_b", 32'(hz.fwd_b_sel), 32'(eb));
    chk("m_busy", 32'(hz.md_busy), 32'(e_busy));
    chk("m_done", 32'(hz.md_done), 32'(e_done));
    chk("m_cnt", hz.stall_cnt, ecnt);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    hz.id_rs        = '0;
    hz.id_rt        = '0;
    hz.id_use_rs    = 1'b0;
    hz.id_use_rt    = 1'b0;
    hz.id_md_start  = 1'b0;
    hz.id_use_hilo  = 1'b0;
    hz.ex_rd        = '0;
    hz.ex_regwrite  = 1'b0;
    hz.ex_memread   = 1'b0;
    hz.mem_rd       = '0;
    hz.mem_regwrite = 1'b0;
  endtask

  initial begin
    idle();
    tick();
    tick();
    chk("rst_fwd_a", 32'(hz.fwd_a_sel), 32'd0);
    chk("rst_fwd_b", 32'(hz.fwd_b_sel), 32'd0);
    chk("rst_busy", 32'(hz.md_busy), 32'd0);
    chk("rst_done", 32'(hz.md_done), 32'd0);
    chk("rst_cnt", hz.stall_cnt, 32'd0);
    rst_n = 1'b1;
    tick();

    // EX -> EX forwarding
    hz.ex_rd = 5'd8; hz.ex_regwrite = 1'b1;
    hz.id_rs = 5'd8; hz.id_use_rs = 1'b1;
    @(negedge clk);
    chk("exex_stall", 32'(hz.stall), 32'd0);
    tick();
    chk("exex_a", 32'(hz.fwd_a_sel), 32'd1);

    // EX/MEM beats MEM/WB
    idle();
    hz.ex_rd = 5'd9; hz.mem_rd = 5'd9;
    hz.ex_regwrite = 1'b1; hz.mem_regwrite = 1'b1;
    hz.id_rt = 5'd9; hz.id_use_rt = 1'b1;
    tick();
    chk("prio_b", 32'(hz.fwd_b_sel), 32'd1);
    hz.ex_regwrite = 1'b0;
    tick();
    chk("prio_memwb_b", 32'(hz.fwd_b_sel), 32'd2);

    // $0 never forwards
    idle();
    hz.ex_regwrite = 1'b1; hz.mem_regwrite = 1'b1;
    hz.id_use_rs = 1'b1;
    tick();
    chk("zero_a", 32'(hz.fwd_a_sel), 32'd0);

    // load-use: one stall, bubble, then MEM/WB forward
    idle();
    hz.ex_memread = 1'b1; hz.ex_regwrite = 1'b1;
    hz.ex_rd = 5'd4; hz.id_rt = 5'd4; hz.id_use_rt = 1'b1;
    @(negedge clk);
    chk("ld_stall", 32'(hz.stall), 32'd1);
    chk("ld_flush", 32'(hz.flush_idex), 32'd1);
    tick();
    chk("ld_bubble_b", 32'(hz.fwd_b_sel), 32'd0);
    hz.ex_memread = 1'b0; hz.ex_regwrite = 1'b0;
    hz.ex_rd = 5'd0;
    hz.mem_rd = 5'd4; hz.mem_regwrite = 1'b1;
    @(negedge clk);
    chk("ld_nostall", 32'(hz.stall), 32'd0);
    tick();
    chk("ld_memwb_b", 32'(hz.fwd_b_sel), 32'd2);

    // mult then mflo held in ID
    idle();
    hz.id_md_start = 1'b1; hz.id_use_hilo = 1'b1;
    @(negedge clk);
    chk("md_start_nostall", 32'(hz.stall), 32'd0);
    tick();
    chk("md_busy_c1", 32'(hz.md_busy), 32'd1);
    hz.id_md_start = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      chk("mflo_stall", 32'(hz.stall), 32'd1);
      tick();
      chk("md_busy_cn", 32'(hz.md_busy), 32'd1);
      chk("md_done_lo", 32'(hz.md_done), 32'd0);
    end
    @(negedge clk);
    chk("mflo_stall_last", 32'(hz.stall), 32'd1);
    tick();
    chk("md_busy_end", 32'(hz.md_busy), 32'd0);
    chk("md_done_pulse", 32'(hz.md_done), 32'd1);
    @(negedge clk);
    chk("mflo_release", 32'(hz.stall), 32'd0);
    idle();
    tick();
    chk("md_done_clear", 32'(hz.md_done), 32'd0);

    // reset during busy cycle 2
    hz.id_md_start = 1'b1; hz.id_use_hilo = 1'b1;
    tick();
    idle();
    tick();
    chk("rmd_busy_c2", 32'(hz.md_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmd_busy", 32'(hz.md_busy), 32'd0);
    chk("rmd_done", 32'(hz.md_done), 32'd0);
    chk("rmd_cnt", hz.stall_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      chk("rmd_no_done", 32'(hz.md_done), 32'd0);
    end

    // three load-use stall cycles
    hz.ex_memread = 1'b1; hz.ex_regwrite = 1'b1;
    hz.ex_rd = 5'd5; hz.id_rs = 5'd5; hz.id_use_rs = 1'b1;
    tick();
    tick();
    tick();
    idle();
    chk("cnt_three", hz.stall_cnt, CNT3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("cnt_rst", hz.stall_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
